// File: rtl/uart_rx_deserializer_if.sv
// Parallel/serial signal bundle between the RX pad synchronizer side and the
// UART RX deserializer; clock and reset stay as plain ports on the block.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_Error;
    logic                  Stop_Error;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Parity_Error, Stop_Error
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Parity_Error, Stop_Error
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection with glitch rejection,
// 3-sample majority per bit, optional parity and stop checking, one-cycle strobes.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  CLK,
    input logic                  RST,
    uart_rx_deserializer_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            p_q;
    logic [5:0]            p_sel;
    logic [5:0]            half;
    logic [5:0]            edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err_q;
    logic [2:0]            samples;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  bit_end;
    logic                  maj;

    // Only 16 and 32 are legal alternatives; anything else falls back to 8.
    always_comb begin
        case (bus.Prescale)
            6'd16:   p_sel = 6'd16;
            6'd32:   p_sel = 6'd32;
            default: p_sel = 6'd8;
        endcase
    end

    assign half    = p_q >> 1;
    assign bit_end = (edge_cnt == p_q - 6'd1);
    assign maj     = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: next-state defaults to the current state up front so no path
        // through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!bus.RX_IN) state_d = S_START;
            S_START:  if (bit_end) state_d = maj ? S_IDLE : S_DATA;
            S_DATA:   if (bit_end && bit_cnt == BIT_W'(DATA_WIDTH - 1))
                          state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q              <= 6'd8;
            par_en_q         <= 1'b0;
            par_typ_q        <= 1'b0;
            par_err_q        <= 1'b0;
            edge_cnt         <= '0;
            bit_cnt          <= '0;
            samples          <= '0;
            shift_q          <= '0;
            bus.P_DATA       <= '0;
            bus.Data_Valid   <= 1'b0;
            bus.Parity_Error <= 1'b0;
            bus.Stop_Error   <= 1'b0;
        end else begin
            bus.Data_Valid   <= 1'b0;
            bus.Parity_Error <= 1'b0;
            bus.Stop_Error   <= 1'b0;

            if (state_q == S_IDLE) begin
                // The detecting cycle itself counts as E=0 of the start bit.
                edge_cnt  <= bus.RX_IN ? 6'd0 : 6'd1;
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
                if (!bus.RX_IN) begin
                    p_q       <= p_sel;
                    par_en_q  <= bus.PAR_EN;
                    par_typ_q <= bus.PAR_TYP;
                end
            end else begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;

                if (edge_cnt == half - 6'd1) samples[0] <= bus.RX_IN;
                if (edge_cnt == half)        samples[1] <= bus.RX_IN;
                if (edge_cnt == half + 6'd1) samples[2] <= bus.RX_IN;

                if (bit_end) begin
                    case (state_q)
                        S_DATA: begin
                            shift_q[bit_cnt] <= maj;
                            bit_cnt          <= bit_cnt + BIT_W'(1);
                        end
                        S_PARITY: par_err_q <= maj ^ (^shift_q) ^ par_typ_q;
                        S_STOP: begin
                            if (!par_err_q && maj) begin
                                bus.P_DATA     <= shift_q;
                                bus.Data_Valid <= 1'b1;
                            end
                            bus.Parity_Error <= par_err_q;
                            bus.Stop_Error   <= ~maj;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are pushed with their expected
// strobe cycle and result, and popped whenever the DUT raises a strobe.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_rx_deserializer_if bus ();
    uart_rx_deserializer dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    // Any strobe must match the head of the scoreboard in cycle and content.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (bus.Data_Valid !== 1'b0 || bus.Parity_Error !== 1'b0 ||
                             bus.Stop_Error !== 1'b0)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe cycle %0d dv=%b pe=%b se=%b",
                         cyc, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL strobe_cycle got %0d want %0d", cyc, mon_e.cyc);
                end
                vectors++;
                if ({bus.Data_Valid, bus.Parity_Error, bus.Stop_Error, bus.P_DATA} !==
                    {mon_e.dv, mon_e.pe, mon_e.se, mon_e.data}) begin
                    miscompares++;
                    $display("FAIL strobe_result got dv=%b pe=%b se=%b data=%h want dv=%b pe=%b se=%b data=%h",
                             bus.Data_Valid, bus.Parity_Error, bus.Stop_Error, bus.P_DATA,
                             mon_e.dv, mon_e.pe, mon_e.se, mon_e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_frame(input logic [5:0] code, input logic [7:0] d, input bit par_en,
                               input bit typ, input bit par_bit, input bit stop_bit,
                               input int noise_bit);
        int   p;
        int   n;
        bit   bits[11];
        bit   pe;
        bit   se;
        exp_t e;
        p = (code == 6'd16) ? 16 : (code == 6'd32) ? 32 : 8;
        n = par_en ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = par_en ? par_bit : stop_bit;
        bits[10] = stop_bit;
        pe = par_en && (par_bit != ((^d) ^ typ));
        se = !stop_bit;
        if (!pe && !se) model_pdata = d;
        e = '{cyc + n * p, !pe && !se, pe, se, model_pdata};
        sb.push_back(e);
        bus.Prescale = code;
        bus.PAR_EN   = par_en;
        bus.PAR_TYP  = typ;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                bus.RX_IN = (i == noise_bit && j == p / 2) ? ~bits[i] : bits[i];
                // Configuration is scrambled right after start detection.
                if (i == 0 && j == 1) begin
                    bus.Prescale = (p == 16) ? 6'd32 : 6'd16;
                    bus.PAR_EN   = ~par_en;
                    bus.PAR_TYP  = ~typ;
                end
                tick(1);
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 3000 && sb.size() != 0; k++) tick(1);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain pending %0d want 0", name, sb.size());
            sb.delete();
        end
        tick(4);
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if ({bus.P_DATA, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error} !== 11'd0) begin
            miscompares++;
            $display("FAIL %s got data=%h dv=%b pe=%b se=%b want all 0", name, bus.P_DATA,
                     bus.Data_Valid, bus.Parity_Error, bus.Stop_Error);
        end
    endtask

    task automatic check_pdata(input string name, input logic [7:0] want);
        vectors++;
        if (bus.P_DATA !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, bus.P_DATA, want);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        tick(3);
        check_outputs_zero("reset_values");
        RST = 1'b1;
        tick(3);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_basic_p8();
        drive_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("basic_p8");
        check_pdata("basic_p8_hold", 8'hA5);
    endtask

    task automatic test_parity_p16();
        drive_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        drive_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        drive_frame(6'd16, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        wait_drain("parity_p16");
        check_pdata("parity_err_hold", 8'h3C);
    endtask

    task automatic test_odd_and_break();
        drive_frame(6'd5, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        drive_frame(6'd5, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        drive_frame(6'd8, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        wait_drain("odd_break");
        check_pdata("odd_valid", 8'h01);
    endtask

    task automatic test_glitch();
        bus.Prescale = 6'd8;
        bus.RX_IN = 1'b0;
        tick(2);
        bus.RX_IN = 1'b1;
        tick(6);
        drive_frame(6'd8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("glitch");
    endtask

    task automatic test_back_to_back();
        drive_frame(6'd32, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drive_frame(6'd32, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        drive_frame(6'd32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        wait_drain("back_to_back");
        check_pdata("back_to_back_last", 8'h81);
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'hF0;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = d[i];
            tick(8);
        end
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        model_pdata = 8'h00;
        tick(2);
        RST = 1'b1;
        tick(10);
        check_outputs_zero("after_mid_reset");
        drive_frame(6'd8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        wait_drain("mid_reset_next");
        check_pdata("mid_reset_next_data", 8'hC3);
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_p16();
        test_odd_and_break();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
